conv_row_sched: RTL
===================

# conv_row_sched

Sequencer that drives the data request generator for one convolution layer pass. On a start command it latches the layer shape and walks the output rows. For each output row it issues one request burst per kernel line, each burst being one input row wide. After each burst it emits a one-cycle line-end pulse. The block sits between the layer control registers and the data request generator, and gates requests against back-pressure from the downstream line FIFO.

## Interface
- REG_WIDTH, 32, width of the configuration shape registers
- KERNEL_SIZE_WIDTH, 2, kernel-size field width; legal kernel sizes are 1..3
- STRIDE_WIDTH, 4, stride field width
- CNT_WIDTH, 8, width of the row, column and line counters
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-low reset
- i_start  input  1  one-cycle start pulse; honoured only in IDLE
- i_abort  input  1  synchronous abort; forces IDLE from any state, with no o_done
- i_fifo_full  input  1  downstream back-pressure; suppresses o_req in the same cycle
- i_conf_inputshape  input  REG_WIDTH  [7:0] input width W, [15:8] input height H
- i_conf_kernelshape  input  REG_WIDTH  [KERNEL_SIZE_WIDTH-1:0] kernel size K
- i_cnfx_stride  input  STRIDE_WIDTH  vertical stride S
- o_req  output  1  read request to the data request generator, one address per cycle
- o_end  output  1  one-cycle kernel-line-end pulse
- o_busy  output  1  high in every state except IDLE
- o_done  output  1  one-cycle pulse when the pass completes or a configuration error ends it
- o_cfg_err  output  1  sticky configuration-error flag; cleared by the next accepted i_start
- o_row_cnt  output  CNT_WIDTH  top input row index of the current output row
- o_line_cnt  output  KERNEL_SIZE_WIDTH  current kernel line index

## Operation
- States: IDLE, LOAD, RUN, LEND, DONE.
- IDLE -> LOAD on i_start. The block latches W, H, K and S. Later config changes are ignored until the next start.
- LOAD lasts one cycle:
  - Error check: W==0, K==0, S==0 or H<K is an error.
  - On error: set o_cfg_err and go to DONE.
  - Otherwise: clear the column, line and row counters and go to RUN.
- RUN:
  - o_req = (state==RUN) & ~i_fifo_full. This is the only combinational output.
  - The column counter increments on each o_req.
  - When o_req is asserted with column==W-1, the counter clears and the next state is LEND.
- LEND lasts one cycle with o_end=1, then one of the following applies:
  - line<K-1: line++, back to RUN.
  - Else, if row+S+K <= H: line=0, row+=S, back to RUN. The sum is computed at CNT_WIDTH+1 bits, so it does not wrap.
  - Else: go to DONE.
- DONE lasts one cycle with o_done=1, then goes to IDLE. o_row_cnt and o_line_cnt hold their last values until the next start.
- i_abort takes priority over every transition, including i_start in the same cycle.
- i_start is ignored outside IDLE.
- i_fifo_full held high stalls RUN indefinitely. No request is lost or duplicated.

## Timing
- Reset values: state IDLE, with o_req, o_end, o_busy, o_done and o_cfg_err all 0, and all counters 0.
- An asynchronous assertion of rst mid-pass clears everything immediately.
- The first o_req is asserted 2 cycles after the i_start cycle (i_start at T, LOAD at T+1, o_req at T+2).
- A burst with no stall takes W consecutive o_req cycles followed by 1 o_end cycle.
- Number of output rows: R = floor((H-K)/S)+1.
- Unstalled pass length, from the first o_req to o_done: R*K*(W+1) cycles, plus 1.
- o_done follows the last o_end by exactly 1 cycle.
- o_end and o_req are never high in the same cycle.
- Each cycle with i_fifo_full high during RUN adds exactly one cycle.

## Test plan
- W=4, H=6, K=3, S=1, no stall.
  - Required: 4 output rows, each with 3 bursts of 4 o_req then 1 o_end.
  - Required: 48 o_req and 12 o_end in total, o_done at cycle T+62.
- W=4, H=7, K=3, S=2.
  - Required: o_row_cnt takes 0, 2 and 4, giving 3 rows.
  - Required: 36 o_req, then o_done; row 6 is never visited.
- Same as case 1 with i_fifo_full high for 3 cycles mid-burst.
  - Required: o_req is low during those cycles.
  - Required: totals are unchanged and o_done is 3 cycles later.
- K=0, or H=2 with K=3.
  - Required: o_cfg_err=1, o_done at T+2, no o_req.
  - Required: a following valid i_start clears o_cfg_err.
- Abort and reset mid-pass.
  - i_abort during the second burst, with i_start in the same cycle: next cycle IDLE, no o_done, o_busy=0.
  - rst low mid-burst: all outputs 0 asynchronously.
- i_start pulses during RUN.
  - Required: ignored; the counts match case 1 exactly.

Source files
------------

// File: rtl/conv_row_sched.sv
// Convolution row sequencer: walks output rows and kernel lines for one layer pass,
// issuing one input-row-wide request burst per kernel line under FIFO back-pressure.
module conv_row_sched #(
  parameter int unsigned REG_WIDTH         = 32,
  parameter int unsigned KERNEL_SIZE_WIDTH = 2,
  parameter int unsigned STRIDE_WIDTH      = 4,
  parameter int unsigned CNT_WIDTH         = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic                         i_fifo_full,
  input  logic [REG_WIDTH-1:0]         i_conf_inputshape,
  input  logic [REG_WIDTH-1:0]         i_conf_kernelshape,
  input  logic [STRIDE_WIDTH-1:0]      i_cnfx_stride,
  output logic                         o_req,
  output logic                         o_end,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_cfg_err,
  output logic [CNT_WIDTH-1:0]         o_row_cnt,
  output logic [KERNEL_SIZE_WIDTH-1:0] o_line_cnt
);

  localparam int unsigned SUM_W = CNT_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, LEND, DONE} state_e;

  state_e                       state_q, state_d;
  logic [CNT_WIDTH-1:0]         w_q, w_d, h_q, h_d;
  logic [KERNEL_SIZE_WIDTH-1:0] k_q, k_d;
  logic [STRIDE_WIDTH-1:0]      s_q, s_d;
  logic [CNT_WIDTH-1:0]         col_q, col_d, row_q, row_d;
  logic [KERNEL_SIZE_WIDTH-1:0] line_q, line_d;
  logic                         cfg_err_q, cfg_err_d;
  logic                         end_q, end_d, busy_q, busy_d, done_q, done_d;
  logic                         req_c;
  logic [SUM_W-1:0]             next_row_end;

  // Shape register bits beyond the used fields are intentionally ignored.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{i_conf_inputshape[REG_WIDTH-1:16],
                             i_conf_kernelshape[REG_WIDTH-1:KERNEL_SIZE_WIDTH]};

  assign req_c        = (state_q == RUN) && !i_fifo_full;
  assign next_row_end = SUM_W'(row_q) + SUM_W'(s_q) + SUM_W'(k_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      k_q       <= '0;
      s_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      line_q    <= '0;
      cfg_err_q <= 1'b0;
      end_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      k_q       <= k_d;
      s_q       <= s_d;
      col_q     <= col_d;
      row_q     <= row_d;
      line_q    <= line_d;
      cfg_err_q <= cfg_err_d;
      end_q     <= end_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    k_d       = k_q;
    s_d       = s_q;
    col_d     = col_q;
    row_d     = row_q;
    line_d    = line_q;
    cfg_err_d = cfg_err_q;

    // Abort outranks every transition, including a same-cycle start.
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d   = LOAD;
            w_d       = CNT_WIDTH'(i_conf_inputshape[7:0]);
            h_d       = CNT_WIDTH'(i_conf_inputshape[15:8]);
            k_d       = i_conf_kernelshape[KERNEL_SIZE_WIDTH-1:0];
            s_d       = i_cnfx_stride;
            cfg_err_d = 1'b0;
          end
        end
        LOAD: begin
          if (w_q == '0 || k_q == '0 || s_q == '0 || SUM_W'(h_q) < SUM_W'(k_q)) begin
            cfg_err_d = 1'b1;
            state_d   = DONE;
          end else begin
            col_d   = '0;
            line_d  = '0;
            row_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (req_c) begin
            if (col_q == w_q - CNT_WIDTH'(1)) begin
              col_d   = '0;
              state_d = LEND;
            end else begin
              col_d = col_q + CNT_WIDTH'(1);
            end
          end
        end
        LEND: begin
          if (line_q < k_q - KERNEL_SIZE_WIDTH'(1)) begin
            line_d  = line_q + KERNEL_SIZE_WIDTH'(1);
            state_d = RUN;
          end else if (next_row_end <= SUM_W'(h_q)) begin
            line_d  = '0;
            row_d   = row_q + CNT_WIDTH'(s_q);
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    end_d  = (state_d == LEND);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign o_req      = req_c;
  assign o_end      = end_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_cfg_err  = cfg_err_q;
  assign o_row_cnt  = row_q;
  assign o_line_cnt = line_q;

endmodule
